gnrl_iq_acq_buffer: RTL and testbench
=====================================

// Module: gnrl_iq_acq_buffer
// PURPOSE
//  Capture buffer directly downstream of the IQ comb decimator. Collects a programmed
//  number of decimated samples (dataout/out_valid) per acquisition window into an
//  on-chip FIFO. A reader drains it with a 1-cycle-latency read handshake.
//  Tracks overflow and the number of completed frames.
// PARAMETERS
//  DATA_WIDTH  32  sample word width; must be >= 32.
//  ADDR_WIDTH  10  FIFO address width; depth = 2**ADDR_WIDTH words (1024).
//  LEN_WIDTH   16  width of acq_len and the internal sample counter.
// PORTS
//  CLK         in   1             system clock; all logic on rising edge.
//  RESET       in   1             synchronous, active-high reset.
//  din         in   DATA_WIDTH    decimated sample (decimator dataout).
//  din_valid   in   1             sample strobe (decimator out_valid).
//  acq_start   in   1             1-cycle pulse; arms capture of one frame.
//  acq_len     in   LEN_WIDTH     samples per frame; sampled on accepted acq_start.
//  acq_busy    out  1             high while in CAPTURE.
//  acq_done    out  1             1-cycle pulse at frame end.
//  frame_cnt   out  16            completed frames; wraps 0xFFFF->0.
//  overflow    out  1             sticky; a word was dropped because the FIFO was full.
//  rd_en       in   1             read request.
//  rd_data     out  DATA_WIDTH    read word, valid when rd_valid=1.
//  rd_valid    out  1             high the cycle after an accepted read.
//  fifo_empty  out  1             fifo_count==0.
//  fifo_full   out  1             fifo_count==2**ADDR_WIDTH.
//  fifo_count  out  ADDR_WIDTH+1  words held.
// BEHAVIOUR
//  - Reset: all outputs 0 except fifo_empty=1. FSM=IDLE. Pointers and counters cleared.
//    Reset mid-frame discards the frame and all FIFO contents.
//  - FSM IDLE: din_valid is ignored.
//    acq_start with acq_len!=0 -> CAPTURE. Latches len, clears the sample counter,
//    clears overflow.
//    acq_start with acq_len==0 -> acq_done pulse next cycle. frame_cnt and FSM unchanged.
//  - FSM CAPTURE: each din_valid writes din if !fifo_full; otherwise the word is dropped
//    and overflow is set. A dropped sample still counts toward len.
//    acq_start is ignored.
//    The valid sample that brings the count to len -> DONE.
//  - FSM DONE (1 cycle): acq_done=1, frame_cnt+=1 -> IDLE.
//    din_valid in DONE is ignored.
//  - Read: rd_en && !fifo_empty pops a word. rd_data and rd_valid are registered
//    one cycle later. rd_en while empty is ignored; rd_valid stays 0.
//    rd_data holds its last value when rd_valid=0.
//  - Full and empty are evaluated on the pre-edge count.
//    Write while full is dropped, even with a simultaneous read.
//    Read while empty is ignored, even with a simultaneous write; there is no fall-through.
//  - Simultaneous accepted write and read: fifo_count is unchanged.
//  - Pointers wrap modulo depth.
//  - Latency: din_valid -> fifo_count increment is 1 cycle.
// CONFIGURATION
//  GNRL_IQ_ACQ_BUF_HDR_EN defined:
//  - On accepted acq_start (acq_len!=0), the header word {frame_cnt, acq_len[15:0]},
//    zero-extended to DATA_WIDTH, is written in the same edge.
//  - If the FIFO is full, the header is dropped and overflow is set.
//  - The header does not count toward len.
//  Undefined: no header is written; the FIFO holds sample words only.
// TESTING
//  1. RESET high 2 cycles -> fifo_empty=1, fifo_count=0, acq_busy=0, acq_done=0,
//     frame_cnt=0, overflow=0.
//  2. acq_len=5, acq_start, 8 din_valid with din=1..8
//     -> fifo_count=5 (6 with HDR_EN), one acq_done pulse, frame_cnt=1.
//     Reads return 1..5, header first when HDR_EN is defined.
//  3. acq_len=1100 with no reads -> fifo_full at 1024 entries, overflow=1,
//     acq_done after the 1100th valid.
//     Then a new acq_start -> overflow=0.
//  4. Full FIFO with rd_en and din_valid in the same cycle -> fifo_count=1023;
//     the din word is absent from the read-out.
//     Empty FIFO with rd_en and din_valid -> rd_valid=0, fifo_count=1.
//  5. acq_start during CAPTURE (len=10) -> ignored; exactly 10 words and one acq_done.
//     acq_start with acq_len=0 -> acq_done pulse, frame_cnt unchanged.
//  6. RESET asserted mid-frame after 3 of 10 samples -> fifo_count=0, acq_busy=0.
//     A following 4-sample frame reads back only those 4 samples.

Source files
------------

// File: rtl/gnrl_iq_acq_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : gnrl_iq_acq_buffer
//  Purpose  : Frame capture buffer behind the IQ comb decimator. An acquisition
//             is armed by acq_start and collects acq_len decimated samples
//             into an on-chip FIFO. The FIFO is drained through a read
//             handshake with 1-cycle latency. The block tracks sticky overflow
//             and counts completed frames.
//  Options  : GNRL_IQ_ACQ_BUF_HDR_EN - when defined, a header word
//             {frame_cnt, acq_len[15:0]} is pushed when a frame is armed.
//  Revision : 1.0 - initial release
// ============================================================================
module gnrl_iq_acq_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    input  logic                  acq_start,
    input  logic [LEN_WIDTH-1:0]  acq_len,
    output logic                  acq_busy,
    output logic                  acq_done,
    output logic [15:0]           frame_cnt,
    output logic                  overflow,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic [ADDR_WIDTH:0]   fifo_count
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [LEN_WIDTH-1:0]    len_q, len_d;
    logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
    logic [15:0]             frame_cnt_q, frame_cnt_d;
    logic                    overflow_q, overflow_d;
    logic                    acq_busy_q, acq_busy_d;
    logic                    acq_done_q, acq_done_d;
    logic [ADDR_WIDTH-1:0]   wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0]   rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]     count_q, count_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                    rd_valid_q, rd_valid_d;

    logic                    wr_req;
    logic                    wr_acc;
    logic                    rd_acc;
    logic                    full_now;
    logic                    empty_now;
    logic [DATA_WIDTH-1:0]   wr_word;

`ifdef GNRL_IQ_ACQ_BUF_HDR_EN
    logic [15:0]             hdr_len;
    logic [DATA_WIDTH-1:0]   hdr_word;
`endif

    logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];

    // Count can never exceed DEPTH, so its MSB alone marks a full FIFO.
    assign full_now  = count_q[ADDR_WIDTH];
    assign empty_now = (count_q == '0);

`ifdef GNRL_IQ_ACQ_BUF_HDR_EN
    // Header word: {frame number, programmed length}, zero-extended.
    always_comb begin
        hdr_len        = 16'(acq_len);
        hdr_word       = '0;
        hdr_word[31:0] = {frame_cnt_q, hdr_len};
    end
`endif

    // Next-state logic for the capture FSM, FIFO pointers and read port.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        frame_cnt_d = frame_cnt_q;
        overflow_d  = overflow_q;
        acq_done_d  = 1'b0;
        wr_req      = 1'b0;
        wr_word     = din;

        case (state_q)
            S_IDLE: begin
                if (acq_start) begin
                    if (acq_len == '0) begin
                        // Empty frame: acknowledge without capturing or counting.
                        acq_done_d = 1'b1;
                    end else begin
                        state_d    = S_CAPTURE;
                        len_d      = acq_len;
                        cnt_d      = '0;
                        overflow_d = 1'b0;
`ifdef GNRL_IQ_ACQ_BUF_HDR_EN
                        wr_req     = 1'b1;
                        wr_word    = hdr_word;
`endif
                    end
                end
            end
            S_CAPTURE: begin
                if (din_valid) begin
                    // Dropped samples still advance the frame count.
                    wr_req = 1'b1;
                    cnt_d  = cnt_q + LEN_WIDTH'(1);
                    if (cnt_d == len_q) begin
                        state_d     = S_DONE;
                        acq_done_d  = 1'b1;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Full/empty use the pre-edge count: no fall-through, no write-while-full.
        wr_acc = wr_req & ~full_now;
        rd_acc = rd_en & ~empty_now;
        if (wr_req && full_now) begin
            overflow_d = 1'b1;
        end

        wptr_d = wr_acc ? (wptr_q + ADDR_WIDTH'(1)) : wptr_q;
        rptr_d = rd_acc ? (rptr_q + ADDR_WIDTH'(1)) : rptr_q;

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        rd_valid_d = rd_acc;
        rd_data_d  = rd_acc ? mem[rptr_q] : rd_data_q;
        acq_busy_d = (state_d == S_CAPTURE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            frame_cnt_q <= '0;
            overflow_q  <= 1'b0;
            acq_busy_q  <= 1'b0;
            acq_done_q  <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            frame_cnt_q <= frame_cnt_d;
            overflow_q  <= overflow_d;
            acq_busy_q  <= acq_busy_d;
            acq_done_q  <= acq_done_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    // FIFO storage; contents need no reset since pointers define validity.
    always_ff @(posedge CLK) begin
        if (wr_acc && !RESET) begin
            mem[wptr_q] <= wr_word;
        end
    end

    assign acq_busy   = acq_busy_q;
    assign acq_done   = acq_done_q;
    assign frame_cnt  = frame_cnt_q;
    assign overflow   = overflow_q;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign fifo_empty = empty_now;
    assign fifo_full  = full_now;
    assign fifo_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_gnrl_iq_acq_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gnrl_iq_acq_buffer
//  Purpose  : Self-checking bench for gnrl_iq_acq_buffer. A queue-based
//             frame/FIFO model predicts every output.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gnrl_iq_acq_buffer;

`ifdef GNRL_IQ_ACQ_BUF_HDR_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam int DEPTH = 1024;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [31:0] din = '0;
    logic        din_valid = 1'b0;
    logic        acq_start = 1'b0;
    logic [15:0] acq_len = '0;
    logic        acq_busy;
    logic        acq_done;
    logic [15:0] frame_cnt;
    logic        overflow;
    logic        rd_en = 1'b0;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        fifo_empty;
    logic        fifo_full;
    logic [10:0] fifo_count;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] m_q[$];
    int          m_left = 0;
    bit          m_cap = 0;
    bit          m_in_done = 0;
    bit          m_done = 0;
    bit          m_ovf = 0;
    bit          m_rdv = 0;
    logic [31:0] m_rdd = '0;
    logic [15:0] m_frames = '0;

    gnrl_iq_acq_buffer #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .LEN_WIDTH(16)) dut (
        .CLK(CLK), .RESET(RESET), .din(din), .din_valid(din_valid),
        .acq_start(acq_start), .acq_len(acq_len), .acq_busy(acq_busy),
        .acq_done(acq_done), .frame_cnt(frame_cnt), .overflow(overflow),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_count(fifo_count)
    );

    always #5 CLK = ~CLK;

    // Drive one clock of stimulus and advance the model by the same edge.
    task automatic cycle(input bit rst, input bit s, input logic [15:0] len,
                         input bit v, input logic [31:0] d, input bit r);
        int sz;
        bit full;
        bit nd;
        bit ni;
        RESET = rst; acq_start = s; acq_len = len; din_valid = v; din = d; rd_en = r;
        @(posedge CLK);
        if (rst) begin
            m_q.delete(); m_cap = 0; m_in_done = 0; m_done = 0; m_ovf = 0;
            m_rdv = 0; m_rdd = '0; m_frames = '0; m_left = 0;
        end else begin
            sz = m_q.size();
            full = (sz == DEPTH);
            nd = 0; ni = 0;
            m_rdv = r && (sz != 0);
            if (m_rdv) m_rdd = m_q.pop_front();
            if (!m_cap && !m_in_done && s) begin
                if (len == 0) nd = 1;
                else begin
                    m_cap = 1; m_left = int'(len); m_ovf = 0;
                    if (HDR == 1) begin
                        if (full) m_ovf = 1;
                        else m_q.push_back({m_frames, len});
                    end
                end
            end else if (m_cap && v) begin
                if (full) m_ovf = 1;
                else m_q.push_back(d);
                m_left--;
                if (m_left == 0) begin
                    m_cap = 0; nd = 1; ni = 1; m_frames++;
                end
            end
            m_done = nd; m_in_done = ni;
        end
        #1;
    endtask

    // Read everything out, comparing each returned word with the model.
    task automatic drain_and_check(input string tag);
        for (int i = 0; i < DEPTH + 4; i++) begin
            if (m_q.size() == 0 && !m_rdv && i > 0) break;
            cycle(0, 0, 0, 0, 0, 1);
            n_vec++;
            if (rd_valid !== m_rdv) begin
                n_err++;
                $display("FAIL %s_rd_valid: got %0b expected %0b", tag, rd_valid, m_rdv);
            end
            n_vec++;
            if (rd_data !== m_rdd) begin
                n_err++;
                $display("FAIL %s_rd_data: got %h expected %h", tag, rd_data, m_rdd);
            end
        end
        cycle(0, 0, 0, 0, 0, 0);
        n_vec++;
        if (fifo_empty !== 1'b1 || fifo_count !== 11'd0) begin
            n_err++;
            $display("FAIL %s_empty: got empty=%0b count=%0d expected 1/0", tag, fifo_empty, fifo_count);
        end
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        n_vec++;
        if ({fifo_empty, fifo_full, acq_busy, acq_done, overflow, rd_valid} !== 6'b100000) begin
            n_err++;
            $display("FAIL reset_flags: got e/f/b/d/o/v=%b expected 100000",
                     {fifo_empty, fifo_full, acq_busy, acq_done, overflow, rd_valid});
        end
        n_vec++;
        if (fifo_count !== 11'd0 || frame_cnt !== 16'd0 || rd_data !== 32'd0) begin
            n_err++;
            $display("FAIL reset_values: got count=%0d frame=%0d rd_data=%h expected 0", fifo_count, frame_cnt, rd_data);
        end
        cycle(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_basic_frame();
        int dones = 0;
        cycle(0, 1, 16'd5, 0, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            cycle(0, 0, 0, 1, 32'(i), 0);
            if (acq_done === 1'b1) dones++;
        end
        n_vec++;
        if (fifo_count !== 11'(5 + HDR)) begin
            n_err++;
            $display("FAIL basic_count: got %0d expected %0d", fifo_count, 5 + HDR);
        end
        n_vec++;
        if (dones != 1 || frame_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL basic_done: got pulses=%0d frame=%0d expected 1/1", dones, frame_cnt);
        end
        drain_and_check("basic");
        n_vec++;
        if (m_rdd !== 32'd5 || rd_data !== 32'd5) begin
            n_err++;
            $display("FAIL basic_last_word: got %h expected 00000005", rd_data);
        end
    endtask

    task automatic test_overflow();
        int dones = 0;
        cycle(0, 1, 16'd1100, 0, 0, 0);
        for (int i = 0; i < 1100; i++) begin
            cycle(0, 0, 0, 1, $urandom, 0);
            if (acq_done === 1'b1) dones++;
            if (i == 1023 - HDR) begin
                n_vec++;
                if (fifo_full !== 1'b1 || fifo_count !== 11'd1024) begin
                    n_err++;
                    $display("FAIL ovf_full_at_1024: got full=%0b count=%0d expected 1/1024", fifo_full, fifo_count);
                end
            end
        end
        n_vec++;
        if (overflow !== 1'b1 || acq_done !== 1'b1 || dones != 1) begin
            n_err++;
            $display("FAIL ovf_end: got ovf=%0b done=%0b pulses=%0d expected 1/1/1", overflow, acq_done, dones);
        end
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 1, 16'd3, 0, 0, 0);
        n_vec++;
        if (overflow !== m_ovf || (HDR == 0 && overflow !== 1'b0)) begin
            n_err++;
            $display("FAIL ovf_cleared: got %0b expected %0b", overflow, m_ovf);
        end
    endtask

    task automatic test_full_and_empty_simul();
        // FIFO full, frame of 3 armed: write+read together.
        cycle(0, 0, 0, 1, 32'hDEAD_BEEF, 1);
        n_vec++;
        if (fifo_count !== 11'd1023 || rd_valid !== 1'b1) begin
            n_err++;
            $display("FAIL full_simul: got count=%0d rd_valid=%0b expected 1023/1", fifo_count, rd_valid);
        end
        drain_and_check("full_drain");
        cycle(0, 0, 0, 1, 32'h1234_5678, 1);
        n_vec++;
        if (rd_valid !== 1'b0 || fifo_count !== 11'd1) begin
            n_err++;
            $display("FAIL empty_simul: got rd_valid=%0b count=%0d expected 0/1", rd_valid, fifo_count);
        end
        cycle(0, 0, 0, 1, 32'h0BAD_F00D, 0);
        n_vec++;
        if (acq_done !== 1'b1 || frame_cnt !== m_frames) begin
            n_err++;
            $display("FAIL empty_simul_done: got done=%0b frame=%0d expected 1/%0d", acq_done, frame_cnt, m_frames);
        end
        drain_and_check("empty_drain");
    endtask

    task automatic test_start_during_capture();
        int dones = 0;
        logic [15:0] f0;
        cycle(0, 1, 16'd10, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            cycle(0, (i == 3), 16'd7, (i % 3 != 2), $urandom, 0);
            if (acq_done === 1'b1) dones++;
        end
        n_vec++;
        if (fifo_count !== 11'(10 + HDR) || dones != 1) begin
            n_err++;
            $display("FAIL restart_ignored: got count=%0d pulses=%0d expected %0d/1", fifo_count, dones, 10 + HDR);
        end
        drain_and_check("restart");
        f0 = frame_cnt;
        cycle(0, 1, 16'd0, 0, 0, 0);
        n_vec++;
        if (acq_done !== 1'b1 || frame_cnt !== f0 || acq_busy !== 1'b0) begin
            n_err++;
            $display("FAIL zero_len: got done=%0b frame=%0d busy=%0b expected 1/%0d/0", acq_done, frame_cnt, acq_busy, f0);
        end
        cycle(0, 0, 0, 0, 0, 0);
        n_vec++;
        if (acq_done !== 1'b0 || fifo_count !== 11'd0) begin
            n_err++;
            $display("FAIL zero_len_after: got done=%0b count=%0d expected 0/0", acq_done, fifo_count);
        end
    endtask

    task automatic test_reset_midframe();
        cycle(0, 1, 16'd10, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, $urandom, 0);
        cycle(1, 0, 0, 0, 0, 0);
        n_vec++;
        if (fifo_count !== 11'd0 || acq_busy !== 1'b0 || fifo_empty !== 1'b1) begin
            n_err++;
            $display("FAIL midframe_reset: got count=%0d busy=%0b expected 0/0", fifo_count, acq_busy);
        end
        cycle(0, 1, 16'd4, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 32'(100 + i), 0);
        n_vec++;
        if (fifo_count !== 11'(4 + HDR)) begin
            n_err++;
            $display("FAIL midframe_next: got count=%0d expected %0d", fifo_count, 4 + HDR);
        end
        drain_and_check("midframe");
    endtask

    task automatic test_random();
        bit s;
        for (int i = 0; i < 600; i++) begin
            s = ($urandom_range(0, 11) == 0);
            cycle(0, s, 16'($urandom_range(0, 24)), $urandom_range(0, 1) == 1,
                  $urandom, $urandom_range(0, 9) < 4);
            n_vec++;
            if (fifo_count !== 11'(m_q.size()) || fifo_empty !== (m_q.size() == 0)) begin
                n_err++;
                $display("FAIL rnd_count: cyc %0d got %0d expected %0d", i, fifo_count, m_q.size());
            end
            n_vec++;
            if (rd_valid !== m_rdv || rd_data !== m_rdd) begin
                n_err++;
                $display("FAIL rnd_read: cyc %0d got v=%0b d=%h expected v=%0b d=%h", i, rd_valid, rd_data, m_rdv, m_rdd);
            end
            n_vec++;
            if (acq_busy !== m_cap || acq_done !== m_done) begin
                n_err++;
                $display("FAIL rnd_fsm: cyc %0d got busy=%0b done=%0b expected %0b/%0b", i, acq_busy, acq_done, m_cap, m_done);
            end
            n_vec++;
            if (frame_cnt !== m_frames || overflow !== m_ovf) begin
                n_err++;
                $display("FAIL rnd_status: cyc %0d got frame=%0d ovf=%0b expected %0d/%0b", i, frame_cnt, overflow, m_frames, m_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_overflow();
        test_full_and_empty_simul();
        test_start_during_capture();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
